// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit that owns the HI/LO registers. Multiply uses a fixed delay line.
// Divide uses a radix-2 restoring iterator. Define MDU_MACC_EN to enable madd/maddu/msub/msubu.
module mdu_iter #(
   parameter int WIDTH   = 32,
   parameter int MUL_LAT = 5,
   parameter int CNT_W   = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             Req,
   input  logic [3:0]       MDUOp,
   input  logic             Start,
   input  logic [WIDTH-1:0] Data1,
   input  logic [WIDTH-1:0] Data2,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic             Busy,
   output logic             Done
);

   // state | meaning
   // IDLE  | no op in flight; accepts mul/div, mthi/mtlo
   // MUL   | product held, counting down the multiply latency
   // DIV   | one restoring step per cycle
   // FIX   | sign correction and HI/LO write of the divide result
   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

   state_t state_q, state_nxt;

   logic [CNT_W-1:0]   cnt_q;
   logic [2*WIDTH-1:0] prod_q;
   logic [WIDTH-1:0]   quo_q, rem_q, dvs_q;
   logic               sgn_r_q, sgn_q_q, dz_q;
   logic               busy_q, done_q;

   logic op_mul, op_div, op_sgn;
   logic acc_mul, acc_div, fin_mul, fin_div, we_hi, we_lo;
   logic cnt_zero;

   logic [2*WIDTH-1:0] a_ext, b_ext, prod_nxt, mul_res;
   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     rem_sh, rem_sub;
   logic               rem_ge;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

`ifdef MDU_MACC_EN
   logic op_mac, op_msub;
   logic mac_en_q, mac_sub_q;
`endif

   always_comb begin
      op_mul = (MDUOp == 4'd1) || (MDUOp == 4'd2);
      op_div = (MDUOp == 4'd3) || (MDUOp == 4'd4);
      op_sgn = (MDUOp == 4'd1) || (MDUOp == 4'd3);
`ifdef MDU_MACC_EN
      op_mac  = (MDUOp >= 4'd7) && (MDUOp <= 4'd10);
      op_msub = (MDUOp == 4'd9) || (MDUOp == 4'd10);
      op_mul  = op_mul || op_mac;
      op_sgn  = op_sgn || (MDUOp == 4'd7) || (MDUOp == 4'd9);
`endif
   end

   always_comb begin
      a_ext    = op_sgn ? {{WIDTH{Data1[WIDTH-1]}}, Data1} : {{WIDTH{1'b0}}, Data1};
      b_ext    = op_sgn ? {{WIDTH{Data2[WIDTH-1]}}, Data2} : {{WIDTH{1'b0}}, Data2};
      prod_nxt = a_ext * b_ext;
      a_neg    = op_sgn & Data1[WIDTH-1];
      b_neg    = op_sgn & Data2[WIDTH-1];
      a_mag    = a_neg ? -Data1 : Data1;
      b_mag    = b_neg ? -Data2 : Data2;
   end

   always_comb begin
      rem_sh  = {rem_q, quo_q[WIDTH-1]};
      rem_sub = rem_sh - {1'b0, dvs_q};
      rem_ge  = (rem_sh >= {1'b0, dvs_q});
      quo_fix = sgn_q_q ? -quo_q : quo_q;
      rem_fix = sgn_r_q ? -rem_q : rem_q;
   end

   // Accumulate forms use HI/LO as they stand at the write edge, so mthi/mtlo can't race them.
   always_comb begin
      mul_res = prod_q;
`ifdef MDU_MACC_EN
      if (mac_en_q)
         mul_res = mac_sub_q ? ({HI, LO} - prod_q) : ({HI, LO} + prod_q);
`endif
   end

   assign cnt_zero = (cnt_q == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_nxt;
   end

   always_comb begin
      state_nxt = state_q;
      acc_mul   = 1'b0;
      acc_div   = 1'b0;
      fin_mul   = 1'b0;
      fin_div   = 1'b0;
      we_hi     = 1'b0;
      we_lo     = 1'b0;
      if (Req) begin
         state_nxt = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (Start && op_mul) begin
                  acc_mul   = 1'b1;
                  state_nxt = S_MUL;
               end else if (Start && op_div) begin
                  acc_div   = 1'b1;
                  state_nxt = S_DIV;
               end else if (MDUOp == 4'd5) begin
                  we_hi = 1'b1;
               end else if (MDUOp == 4'd6) begin
                  we_lo = 1'b1;
               end
            end
            S_MUL: begin
               if (cnt_zero) begin
                  fin_mul   = 1'b1;
                  state_nxt = S_IDLE;
               end
            end
            S_DIV: begin
               if (cnt_zero) state_nxt = S_FIX;
            end
            S_FIX: begin
               fin_div   = 1'b1;
               state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q   <= '0;
         prod_q  <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dvs_q   <= '0;
         sgn_r_q <= 1'b0;
         sgn_q_q <= 1'b0;
         dz_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         HI      <= '0;
         LO      <= '0;
`ifdef MDU_MACC_EN
         mac_en_q  <= 1'b0;
         mac_sub_q <= 1'b0;
`endif
      end else begin
         done_q <= fin_mul | fin_div;
         if (Req) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
         end else if (acc_mul) begin
            busy_q <= 1'b1;
            cnt_q  <= CNT_W'(MUL_LAT - 1);
            prod_q <= prod_nxt;
`ifdef MDU_MACC_EN
            mac_en_q  <= op_mac;
            mac_sub_q <= op_msub;
`endif
         end else if (acc_div) begin
            busy_q  <= 1'b1;
            cnt_q   <= CNT_W'(WIDTH - 1);
            quo_q   <= a_mag;
            rem_q   <= '0;
            dvs_q   <= b_mag;
            sgn_r_q <= a_neg;
            sgn_q_q <= a_neg ^ b_neg;
            dz_q    <= (Data2 == '0);
         end else if (state_q == S_DIV) begin
            rem_q <= rem_ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], rem_ge};
            if (!cnt_zero) cnt_q <= cnt_q - 1'b1;
         end else if (state_q == S_MUL && !cnt_zero) begin
            cnt_q <= cnt_q - 1'b1;
         end else if (fin_mul || fin_div) begin
            busy_q <= 1'b0;
         end

         // Divide by zero: the iterator already leaves |Data1| in the remainder, so only LO needs overriding.
         if (fin_mul) begin
            {HI, LO} <= mul_res;
         end else if (fin_div) begin
            LO <= dz_q ? '1 : quo_fix;
            HI <= rem_fix;
         end else if (we_hi) begin
            HI <= Data1;
         end else if (we_lo) begin
            LO <= Data1;
         end
      end
   end

   assign Busy = busy_q;
   assign Done = done_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed test-plan cases plus randomized ops against an arithmetic model.
module tb_mdu_iter;
   localparam int W       = 32;
   localparam int ML      = 5;
   localparam int DIV_LAT = W + 1;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          Req = 1'b0;
   logic          Start = 1'b0;
   logic [3:0]    MDUOp = 4'd0;
   logic [W-1:0]  Data1 = '0;
   logic [W-1:0]  Data2 = '0;
   logic [W-1:0]  HI, LO;
   logic          Busy, Done;

   int            n_chk = 0;
   int            n_fail = 0;
   logic [63:0]   m_hilo = '0;

   mdu_iter #(.WIDTH(W), .MUL_LAT(ML), .CNT_W(6)) dut (
      .clk(clk), .reset(reset), .Req(Req), .MDUOp(MDUOp), .Start(Start),
      .Data1(Data1), .Data2(Data2), .HI(HI), .LO(LO), .Busy(Busy), .Done(Done)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] ref_op(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] hilo);
      longint      sa, sb, sq, sr;
      logic [63:0] sprod, uprod, qv, rv;
      sa    = longint'($signed(a));
      sb    = longint'($signed(b));
      sprod = 64'(sa * sb);
      uprod = {32'd0, a} * {32'd0, b};
      case (op)
         4'd1:  return sprod;
         4'd2:  return uprod;
         4'd3, 4'd4: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            if (op == 4'd3) begin
               sq = sa / sb;
               sr = sa % sb;
               qv = 64'(sq);
               rv = 64'(sr);
            end else begin
               qv = {32'd0, a / b};
               rv = {32'd0, a % b};
            end
            return {rv[31:0], qv[31:0]};
         end
         4'd7:  return hilo + sprod;
         4'd8:  return hilo + uprod;
         4'd9:  return hilo - sprod;
         4'd10: return hilo - uprod;
         default: return hilo;
      endcase
   endfunction

   task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      MDUOp = op;
      Data1 = a;
      Data2 = b;
      Start = 1'b1;
      tick();
      Start = 1'b0;
      MDUOp = 4'd0;
   endtask

   task automatic wait_done(input string tag, input int lat, input logic [63:0] exp);
      int k = 0;
      bit busy_ok = 1'b1;
      while (!Done && k < 200) begin
         if (!Busy) busy_ok = 1'b0;
         tick();
         k++;
      end
      check({tag, " latency"}, 64'(k), 64'(lat));
      check({tag, " busy_held"}, 64'(busy_ok), 64'd1);
      check({tag, " busy_clear"}, 64'(Busy), 64'd0);
      check({tag, " hilo"}, {HI, LO}, exp);
      m_hilo = exp;
      tick();
      check({tag, " done_pulse"}, 64'(Done), 64'd0);
   endtask

   task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] exp;
      exp = ref_op(op, a, b, m_hilo);
      start_op(op, a, b);
      wait_done(tag, (op == 4'd3 || op == 4'd4) ? DIV_LAT : ML, exp);
   endtask

   task automatic mt(input logic [3:0] op, input logic [31:0] v);
      MDUOp = op;
      Data1 = v;
      tick();
      MDUOp = 4'd0;
      if (op == 4'd5) m_hilo[63:32] = v;
      else            m_hilo[31:0]  = v;
      check("mt hilo", {HI, LO}, m_hilo);
      check("mt busy", 64'(Busy | Done), 64'd0);
   endtask

   function automatic logic [31:0] pick_operand(input int sel);
      case (sel)
         0: return 32'd0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      bit seen;
      logic [63:0] exp;
      logic [3:0]  rop;

      repeat (2) tick();
      reset = 1'b1;
      tick();
      check("reset HI", 64'(HI), 64'd0);
      check("reset LO", 64'(LO), 64'd0);
      check("reset Busy", 64'(Busy), 64'd0);
      check("reset Done", 64'(Done), 64'd0);

      run_op("mult -2*3", 4'd1, 32'hFFFF_FFFE, 32'd3);
      check("mult const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFA);
      run_op("multu", 4'd2, 32'hFFFF_FFFE, 32'd3);
      check("multu const", {HI, LO}, 64'h0000_0002_FFFF_FFFA);
      run_op("div -7/2", 4'd3, 32'hFFFF_FFF9, 32'd2);
      check("div const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op("divu 7/0", 4'd4, 32'd7, 32'd0);
      check("divu0 const", {HI, LO}, 64'h0000_0007_FFFF_FFFF);
      run_op("div ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      check("div ovf const", {HI, LO}, 64'h0000_0000_8000_0000);
      run_op("div -9/0", 4'd3, 32'hFFFF_FFF7, 32'd0);

      // abort at cycle 10 of a divide
      mt(4'd5, 32'h0000_AAAA);
      mt(4'd6, 32'h0000_5555);
      start_op(4'd4, 32'd100, 32'd7);
      repeat (9) tick();
      Req = 1'b1;
      tick();
      Req = 1'b0;
      check("abort busy", 64'(Busy), 64'd0);
      check("abort done", 64'(Done), 64'd0);
      check("abort hilo", {HI, LO}, m_hilo);
      seen = 1'b0;
      repeat (40) begin
         seen |= Done | Busy;
         tick();
      end
      check("abort quiet", 64'(seen), 64'd0);

      // Start together with Req is not accepted
      MDUOp = 4'd1; Data1 = 32'd3; Data2 = 32'd4; Start = 1'b1; Req = 1'b1;
      tick();
      Start = 1'b0; Req = 1'b0; MDUOp = 4'd0;
      check("req start busy", 64'(Busy), 64'd0);
      seen = 1'b0;
      repeat (8) begin
         seen |= Done;
         tick();
      end
      check("req start done", 64'(seen), 64'd0);
      check("req start hilo", {HI, LO}, m_hilo);

      // Req on the final multiply edge wins
      start_op(4'd1, 32'd5, 32'd6);
      repeat (ML - 1) tick();
      Req = 1'b1;
      tick();
      Req = 1'b0;
      check("late abort done", 64'(Done), 64'd0);
      check("late abort busy", 64'(Busy), 64'd0);
      check("late abort hilo", {HI, LO}, m_hilo);

      // mtlo and Start ignored while a divide is running
      exp = ref_op(4'd3, 32'hFFFF_FF9C, 32'd7, m_hilo);
      start_op(4'd3, 32'hFFFF_FF9C, 32'd7);
      tick();
      MDUOp = 4'd6; Data1 = 32'h1234;
      tick();
      MDUOp = 4'd0;
      check("mtlo busy ignored", 64'(LO), {32'd0, m_hilo[31:0]});
      MDUOp = 4'd1; Data1 = 32'd9; Data2 = 32'd9; Start = 1'b1;
      tick();
      Start = 1'b0; MDUOp = 4'd0;
      wait_done("div under traffic", DIV_LAT - 3, exp);
      mt(4'd6, 32'h1234);

      // asynchronous reset in the middle of a divide
      mt(4'd5, 32'hDEAD_BEEF);
      start_op(4'd3, 32'd1000, 32'd3);
      repeat (5) tick();
      #2 reset = 1'b0;
      #1;
      check("midreset HI", 64'(HI), 64'd0);
      check("midreset LO", 64'(LO), 64'd0);
      check("midreset Busy", 64'(Busy), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      m_hilo = '0;
      seen = 1'b0;
      repeat (40) begin
         seen |= Busy | Done;
         tick();
      end
      check("midreset quiet", 64'(seen), 64'd0);

`ifdef MDU_MACC_EN
      mt(4'd5, 32'd0);
      mt(4'd6, 32'hFFFF_FFFF);
      run_op("maddu", 4'd8, 32'd1, 32'd1);
      check("maddu const", {HI, LO}, 64'h0000_0001_0000_0000);
      mt(4'd6, 32'd0);
      mt(4'd5, 32'd0);
      run_op("msub", 4'd9, 32'd1, 32'd1);
      check("msub const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFF);
      run_op("madd", 4'd7, 32'hFFFF_FFFD, 32'd7);
      run_op("msubu", 4'd10, 32'hFFFF_FFFD, 32'd7);
`else
      start_op(4'd7, 32'd1, 32'd1);
      check("op7 busy", 64'(Busy), 64'd0);
      seen = 1'b0;
      repeat (8) begin
         seen |= Done | Busy;
         tick();
      end
      check("op7 quiet", 64'(seen), 64'd0);
      check("op7 hilo", {HI, LO}, m_hilo);
`endif

      for (int i = 0; i < 40; i++) begin
`ifdef MDU_MACC_EN
         rop = 4'($urandom_range(0, 7));
         if (rop > 4'd3) rop = rop + 4'd3;
         else            rop = rop + 4'd1;
`else
         rop = 4'($urandom_range(1, 4));
`endif
         if ($urandom_range(0, 3) == 0) mt(4'($urandom_range(5, 6)), $urandom);
         run_op("random", rop, pick_operand($urandom_range(0, 7)), pick_operand($urandom_range(0, 7)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
